// File: rtl/wddl_pkg.sv
// rtl/wddl_pkg.sv - shared types and widths for the WDDL dual-rail register stage
package wddl_pkg;

  localparam int ERR_CNT_W   = 8;
  localparam int PRECH_CNT_W = 4;

  typedef enum logic [1:0] {
    PRECH = 2'd0,
    IDLE  = 2'd1,
    EVAL  = 2'd2
  } state_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wddl_enc_chk.sv
// rtl/wddl_enc_chk.sv - flags any bit whose rails are equal (00 spacer or 11 illegal)
module wddl_enc_chk #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_d_p,
  input  logic [WIDTH-1:0] i_d_n,
  output logic             o_viol
);

  logic [WIDTH-1:0] w_same;

  assign w_same = ~(i_d_p ^ i_d_n);
  assign o_viol = |w_same;

endmodule

// File: rtl/wddl_dr_reg_stage.sv
// rtl/wddl_dr_reg_stage.sv - dual-rail WDDL pipeline register with precharge wave and encoding check
module wddl_dr_reg_stage
  import wddl_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int PRECH_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     d_p_in,
  input  logic [WIDTH-1:0]     d_n_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     q_p_out,
  output logic [WIDTH-1:0]     q_n_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 prech_out,
  input  logic                 err_clr,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (PRECH_CYCLES < 1 || PRECH_CYCLES > 15) begin : g_bad_prech
    $error("wddl_dr_reg_stage: PRECH_CYCLES must be within 1..15");
  end

  localparam logic [PRECH_CNT_W-1:0] CNT_RELOAD = PRECH_CNT_W'(PRECH_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PRECH_CNT_W-1:0] r_cnt;
  logic [PRECH_CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]       r_q_p;
  logic [WIDTH-1:0]       r_q_n;
  logic [WIDTH-1:0]       w_q_p_nxt;
  logic [WIDTH-1:0]       w_q_n_nxt;
  logic                   r_err_pulse;
  logic                   r_err_sticky;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic                   w_err_pulse_nxt;
  logic                   w_err_sticky_nxt;
  logic [ERR_CNT_W-1:0]   w_err_cnt_nxt;
  logic                   w_capture;
  logic                   w_viol;

  wddl_enc_chk #(
    .WIDTH (WIDTH)
  ) u_enc_chk (
    .i_d_p  (d_p_in),
    .i_d_n  (d_n_in),
    .o_viol (w_viol)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PRECH;
      r_cnt        <= CNT_RELOAD;
      r_q_p        <= '0;
      r_q_n        <= '0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_q_p        <= w_q_p_nxt;
      r_q_n        <= w_q_n_nxt;
      r_err_pulse  <= w_err_pulse_nxt;
      r_err_sticky <= w_err_sticky_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  // Rails only ever move spacer->word on capture and word->spacer on release.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_p_nxt   = r_q_p;
    w_q_n_nxt   = r_q_n;
    w_capture   = 1'b0;
    case (r_state)
      PRECH: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      IDLE: begin
        if (in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = EVAL;
          w_q_p_nxt   = d_p_in;
          w_q_n_nxt   = d_n_in;
        end
      end
      EVAL: begin
        if (out_ready) begin
          w_state_nxt = PRECH;
          w_cnt_nxt   = CNT_RELOAD;
          w_q_p_nxt   = '0;
          w_q_n_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = PRECH;
        w_cnt_nxt   = CNT_RELOAD;
        w_q_p_nxt   = '0;
        w_q_n_nxt   = '0;
      end
    endcase
  end

  // A fresh violation outranks a same-cycle clear so it is never lost.
  always_comb begin
    w_err_pulse_nxt  = w_capture & w_viol;
    w_err_sticky_nxt = r_err_sticky;
    w_err_cnt_nxt    = r_err_cnt;
    if (w_capture && w_viol) begin
      w_err_sticky_nxt = 1'b1;
      w_err_cnt_nxt    = err_clr ? ERR_CNT_W'(1) : sat_inc(r_err_cnt);
    end else if (err_clr) begin
      w_err_sticky_nxt = 1'b0;
      w_err_cnt_nxt    = '0;
    end
  end

  assign q_p_out    = r_q_p;
  assign q_n_out    = r_q_n;
  assign out_valid  = (r_state == EVAL);
  assign in_ready   = (r_state == IDLE);
  assign prech_out  = (r_state == PRECH);
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_wddl_dr_reg_stage.sv
// tb/tb_wddl_dr_reg_stage.sv - directed self-checking bench for wddl_dr_reg_stage
module tb_wddl_dr_reg_stage;

  logic       clk;
  logic       rst_n;
  logic [7:0] d_p_in;
  logic [7:0] d_n_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] q_p_out;
  logic [7:0] q_n_out;
  logic       out_valid;
  logic       out_ready;
  logic       prech_out;
  logic       err_clr;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] err_cnt;

  int n_cmp;
  int n_err;

  wddl_dr_reg_stage #(
    .WIDTH        (8),
    .PRECH_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_p_in     (d_p_in),
    .d_n_in     (d_n_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .q_p_out    (q_p_out),
    .q_n_out    (q_n_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .prech_out  (prech_out),
    .err_clr    (err_clr),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rails(input string tag, input logic [7:0] p, input logic [7:0] n);
    chk({tag, "_qp"}, {24'd0, q_p_out}, {24'd0, p});
    chk({tag, "_qn"}, {24'd0, q_n_out}, {24'd0, n});
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("reach_idle", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    d_p_in    = 8'h00;
    d_n_in    = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;

    #1;
    chk("rst_prech", {31'd0, prech_out}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_rails("rst", 8'h00, 8'h00);
    chk("rst_err", {22'd0, err_pulse, err_sticky, err_cnt}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("prech_c1", {31'd0, prech_out}, 32'd1);
    chk("prech_c1_rdy", {31'd0, in_ready}, 32'd0);
    chk_rails("prech_c1", 8'h00, 8'h00);
    @(negedge clk);
    chk("idle_rdy", {31'd0, in_ready}, 32'd1);
    chk("idle_prech", {31'd0, prech_out}, 32'd0);
    chk_rails("idle", 8'h00, 8'h00);

    d_p_in    = 8'hA5;
    d_n_in    = 8'h5A;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk_rails("eval1", 8'hA5, 8'h5A);
    chk("eval1_valid", {31'd0, out_valid}, 32'd1);
    chk("eval1_rdy", {31'd0, in_ready}, 32'd0);
    chk("eval1_pulse", {31'd0, err_pulse}, 32'd0);
    @(negedge clk);
    chk_rails("post1_a", 8'h00, 8'h00);
    chk("post1_a_prech", {31'd0, prech_out}, 32'd1);
    chk("post1_a_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk_rails("post1_b", 8'h00, 8'h00);
    chk("post1_b_prech", {31'd0, prech_out}, 32'd1);
    @(negedge clk);
    chk("post1_idle", {31'd0, in_ready}, 32'd1);
    chk("post1_noerr", {23'd0, err_sticky, err_cnt}, 32'd0);

    d_p_in    = 8'hA5;
    d_n_in    = 8'h5A;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk_rails("stall", 8'hA5, 8'h5A);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_prech", {31'd0, prech_out}, 32'd0);
      if (i == 0) begin
        d_p_in = 8'hFF;
        d_n_in = 8'hFF;
      end
      if (i < 4) @(negedge clk);
    end
    chk("stall_ignored_err", {23'd0, err_sticky, err_cnt}, 32'd0);
    in_valid  = 1'b0;
    d_p_in    = 8'h00;
    d_n_in    = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_prech", {31'd0, prech_out}, 32'd1);
    chk_rails("stall_release", 8'h00, 8'h00);
    wait_idle();

    d_p_in   = 8'hFF;
    d_n_in   = 8'h01;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("viol_pulse", {31'd0, err_pulse}, 32'd1);
    chk("viol_sticky", {31'd0, err_sticky}, 32'd1);
    chk("viol_cnt", {24'd0, err_cnt}, 32'd1);
    chk_rails("viol", 8'hFF, 8'h01);
    @(negedge clk);
    chk("viol_pulse_drop", {31'd0, err_pulse}, 32'd0);
    chk("viol_sticky_hold", {31'd0, err_sticky}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_sticky", {31'd0, err_sticky}, 32'd0);
    chk("clr_cnt", {24'd0, err_cnt}, 32'd0);
    wait_idle();

    for (int w = 0; w < 300; w++) begin
      d_p_in   = 8'h00;
      d_n_in   = 8'h00;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (w == 9)   chk("sat_cnt10", {24'd0, err_cnt}, 32'd10);
      if (w == 254) chk("sat_cnt255", {24'd0, err_cnt}, 32'd255);
      wait_idle();
    end
    chk("sat_hold", {24'd0, err_cnt}, 32'd255);

    d_p_in   = 8'h0F;
    d_n_in   = 8'h0F;
    in_valid = 1'b1;
    err_clr  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    err_clr  = 1'b0;
    chk("clr_vs_viol_cnt", {24'd0, err_cnt}, 32'd1);
    chk("clr_vs_viol_sticky", {31'd0, err_sticky}, 32'd1);
    chk("clr_vs_viol_pulse", {31'd0, err_pulse}, 32'd1);
    wait_idle();

    d_p_in    = 8'h3C;
    d_n_in    = 8'hC3;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk_rails("pre_rst", 8'h3C, 8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rails("async_rst", 8'h00, 8'h00);
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_prech", {31'd0, prech_out}, 32'd1);
    chk("async_rst_err", {23'd0, err_sticky, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("restart_prech", {31'd0, prech_out}, 32'd1);
    @(negedge clk);
    chk("restart_idle", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
